// File: rtl/quic_rx_pkg.sv
// Shared constants and types for the QUIC/UDP Manchester receive front end.
package quic_rx_pkg;

    localparam int unsigned FRAME_BITS = 464;
    localparam int unsigned DATA_BITS  = 134;
    localparam int unsigned PORT_BITS  = 16;
    localparam int unsigned SRC_MSB    = 463;
    localparam int unsigned DST_MSB    = 447;
    localparam int unsigned CNT_BITS   = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/pass_through_rx_if.sv
// Line input and parallel frame/field outputs of the Manchester receiver.
interface pass_through_rx_if;
    import quic_rx_pkg::*;

    logic                  encoded;
    logic [FRAME_BITS-1:0] decoded;
    logic [PORT_BITS-1:0]  source_port;
    logic [PORT_BITS-1:0]  dest_port;
    logic [DATA_BITS-1:0]  data;

    // master drives the line and consumes the frame; slave is the receiver
    modport master (
        output encoded,
        input  decoded, source_port, dest_port, data
    );

    modport slave (
        input  encoded,
        output decoded, source_port, dest_port, data
    );
endinterface

// File: rtl/manchester_pair_dec.sv
// Pairs Manchester half-symbols and classifies each pair on its second half.
module manchester_pair_dec (
    input  logic clk,
    input  logic rst_n,
    input  logic encoded,
    output logic bit_valid,
    output logic bit_val,
    output logic idle,
    output logic violation
);
    logic phase;
    logic first_half;

    // phase=0 marks a first-half sample; the pair resolves when phase=1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 1'b0;
            first_half <= 1'b0;
        end else begin
            phase <= ~phase;
            if (!phase) begin
                first_half <= encoded;
            end
        end
    end

    // Classification is combinational so the bit lands on the second-half edge
    assign bit_valid = phase & (first_half ^ encoded);
    assign bit_val   = encoded;
    assign idle      = phase & ~first_half & ~encoded;
    assign violation = phase & first_half & encoded;

endmodule

// File: rtl/pass_through_rx.sv
// Manchester frame capture: hunts for a frame, shifts 464 bits in, latches them.
module pass_through_rx
    import quic_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    pass_through_rx_if.slave bus
);
    logic                  bit_valid;
    logic                  bit_val;
    logic                  idle;
    logic                  violation;
    rx_state_e             state;
    logic [CNT_BITS-1:0]   count;
    logic [FRAME_BITS-2:0] hist;
    logic [FRAME_BITS-1:0] frame_next;
    logic [FRAME_BITS-1:0] decoded_q;

    manchester_pair_dec u_pair_dec (
        .clk       (clk),
        .rst_n     (rst_n),
        .encoded   (bus.encoded),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .idle      (idle),
        .violation (violation)
    );

    // The oldest shift bit would only ever fall off the end, so it is not stored
    assign frame_next = {hist, bit_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            count     <= '0;
            hist      <= '0;
            decoded_q <= '0;
        end else begin
            case (state)
                HUNT: begin
                    if (bit_valid) begin
                        hist  <= frame_next[FRAME_BITS-2:0];
                        count <= CNT_BITS'(1);
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (bit_valid) begin
                        hist <= frame_next[FRAME_BITS-2:0];
                        if (count == CNT_BITS'(FRAME_BITS - 1)) begin
                            decoded_q <= frame_next;
                            state     <= DONE;
                        end
                        if (count != {CNT_BITS{1'b1}}) begin
                            count <= count + CNT_BITS'(1);
                        end
                    end else if (idle || violation) begin
                        count <= '0;
                        state <= HUNT;
                    end
                end
                DONE: begin
                    // Trailing valid bits are frame tail; only idle rearms
                    if (idle) begin
                        count <= '0;
                        state <= HUNT;
                    end
                end
                default: begin
                    count <= '0;
                    state <= HUNT;
                end
            endcase
        end
    end

    assign bus.decoded     = decoded_q;
    assign bus.source_port = decoded_q[SRC_MSB -: PORT_BITS];
    assign bus.dest_port   = decoded_q[DST_MSB -: PORT_BITS];
    assign bus.data        = decoded_q[DATA_BITS-1:0];

endmodule

// File: tb/tb_pass_through_rx.sv
// Scoreboard bench for pass_through_rx: frames queued at drive time, checked on latch.
module tb_pass_through_rx;
    import quic_rx_pkg::*;

    typedef struct {
        logic [FRAME_BITS-1:0] frame;
        int unsigned           edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pass_through_rx_if bus ();

    pass_through_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t                  sb[$];
    int unsigned           n_checks = 0;
    int unsigned           n_fail = 0;
    int unsigned           edge_cnt;
    int unsigned           sample_idx = 0;
    logic [FRAME_BITS-1:0] prev_dec = '0;
    logic [FRAME_BITS-1:0] hold_exp = '0;

    task automatic check_eq(input string tag, input logic [FRAME_BITS-1:0] act,
                            input logic [FRAME_BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Rising edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Every change of decoded must match the oldest queued frame and its edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_dec = '0;
            hold_exp = '0;
        end else if (bus.decoded !== prev_dec) begin
            prev_dec = bus.decoded;
            if (sb.size() == 0) begin
                check_eq("spurious_update", bus.decoded, hold_exp);
            end else begin
                e = sb.pop_front();
                hold_exp = e.frame;
                check_eq("decoded", bus.decoded, e.frame);
                check_eq("source_port", bus.source_port, e.frame[SRC_MSB -: PORT_BITS]);
                check_eq("dest_port", bus.dest_port, e.frame[DST_MSB -: PORT_BITS]);
                check_eq("data", bus.data, e.frame[DATA_BITS-1:0]);
                check_eq("latch_edge", edge_cnt, e.edge_no);
            end
        end
    end

    task automatic send_sample(input logic b);
        bus.encoded = b;
        @(negedge clk);
        sample_idx++;
    endtask

    task automatic send_bit(input logic b);
        send_sample(~b);
        send_sample(b);
    endtask

    task automatic send_idle();
        send_sample(1'b0);
        send_sample(1'b0);
    endtask

    task automatic send_viol();
        send_sample(1'b1);
        send_sample(1'b1);
    endtask

    // Full frame; expected latch is the edge sampling the last pair's second half
    task automatic send_frame(input logic [FRAME_BITS-1:0] f);
        exp_t e;
        for (int i = 0; i < int'(FRAME_BITS); i++) begin
            if (i == int'(FRAME_BITS) - 1) begin
                e.frame   = f;
                e.edge_no = sample_idx + 2;
                sb.push_back(e);
            end
            send_bit(f[FRAME_BITS-1-i]);
        end
    endtask

    task automatic send_partial(input logic [FRAME_BITS-1:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[FRAME_BITS-1-i]);
    endtask

    function automatic logic [FRAME_BITS-1:0] rand_frame();
        logic [FRAME_BITS-1:0] r;
        for (int k = 0; k < int'(FRAME_BITS); k++) r[k] = 1'($urandom);
        return r;
    endfunction

    task automatic check_reset_zero(input string tag);
        check_eq({tag, "_decoded"}, bus.decoded, '0);
        check_eq({tag, "_source_port"}, bus.source_port, '0);
        check_eq({tag, "_dest_port"}, bus.dest_port, '0);
        check_eq({tag, "_data"}, bus.data, '0);
    endtask

    initial begin
        logic [FRAME_BITS-1:0] f;
        logic [FRAME_BITS-1:0] f_prev;
        logic [DATA_BITS-1:0]  alt_data;
        logic [DATA_BITS-1:0]  ones_data;

        bus.encoded = 1'b0;
        repeat (8) begin
            @(negedge clk);
            bus.encoded = 1'($urandom);
        end
        check_reset_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;
        sample_idx = 0;

        // All-ones frame straight after release latches at edge 928
        f = '1;
        send_frame(f);
        send_idle();
        ones_data = '1;
        check_eq("ones_source_port", bus.source_port, 16'hFFFF);
        check_eq("ones_dest_port", bus.dest_port, 16'hFFFF);
        check_eq("ones_data", bus.data, ones_data);

        // Field mapping: ports then alternating 1,0 ending on a 0
        f[463:448] = 16'h1234;
        f[447:432] = 16'hABCD;
        for (int i = 32; i < int'(FRAME_BITS); i++) f[FRAME_BITS-1-i] = ((i - 32) % 2) == 0;
        send_frame(f);
        send_idle();
        alt_data = {67{2'b10}};
        check_eq("map_source_port", bus.source_port, 16'h1234);
        check_eq("map_dest_port", bus.dest_port, 16'hABCD);
        check_eq("map_data", bus.data, alt_data);
        f_prev = f;

        // Short frame followed by idle leaves outputs alone
        send_partial(rand_frame(), 200);
        send_idle();
        check_eq("short_hold", bus.decoded, f_prev);

        // Long frame: 488 bits, only the first 464 count
        f = rand_frame();
        send_frame(f);
        for (int i = 0; i < 24; i++) send_bit(1'($urandom));
        repeat (3) send_idle();
        check_eq("long_hold", bus.decoded, f);

        // Abort after 100 bits, then a 16'h0F0F frame
        send_partial(rand_frame(), 100);
        send_viol();
        for (int k = 0; k < int'(FRAME_BITS / 16); k++) f[FRAME_BITS-1-16*k -: 16] = 16'h0F0F;
        send_frame(f);
        send_idle();
        check_eq("abort_frame", bus.decoded, f);

        // Back-to-back frames separated by a single idle pair
        f = rand_frame();
        send_frame(f);
        send_idle();
        f = rand_frame();
        send_frame(f);
        send_idle();
        check_eq("b2b_second", bus.decoded, f);

        // Reset mid-frame clears outputs; pairing restarts on release
        send_partial(rand_frame(), 150);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            bus.encoded = 1'($urandom);
        end
        check_reset_zero("midreset");
        rst_n = 1'b1;
        sample_idx = 0;
        f = rand_frame();
        send_frame(f);
        repeat (4) send_idle();

        check_eq("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pass_through_rx.md
# pass_through_rx

Serial Manchester receive front end for the QUIC/UDP datapath. It decodes a one-bit Manchester line sampled once per clock into NRZ bits and captures the first 464 decoded bits of a frame. It presents the captured frame plus fixed-offset fields (source port, destination port, payload) as parallel words for downstream header and payload logic.

## Interface
Parameters (fixed by design; use package constants):
- FRAME_BITS, 464, number of decoded bits captured per frame
- DATA_BITS, 134, payload field width

Ports:
- clk  in  1  system clock; all sampling on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- encoded  in  1  Manchester line, one half-symbol per clock
- decoded  out  464  captured frame; first received bit in bit 463
- source_port  out  16  decoded[463:448]
- dest_port  out  16  decoded[447:432]
- data  out  134  decoded[133:0]

## Operation
- Half-symbol pairing:
  - A phase flag toggles every clock from reset release.
  - The first sample after reset is a first half.
  - Each pair (first, second) is evaluated when the second half is sampled.
- Pair decode:
  - "01" -> 1
  - "10" -> 0
  - "00" -> idle
  - "11" -> code violation
- States:
  - HUNT: valid pair -> shift the bit in, count = 1, go to RECV. Idle or violation -> stay.
  - RECV: valid pair -> shift into an internal 464-bit shift register, MSB-first (new bit enters bit 0, older bits move toward 463), count++.
    - When count reaches 464 -> latch the shift register into `decoded` and go to DONE.
    - Idle or violation -> discard the partial frame, clear count, go to HUNT. Outputs are unchanged.
  - DONE: ignore valid pairs (frame tail/FCS). Idle pair -> HUNT. Violation -> stay.
- Output derivation:
  - `source_port`, `dest_port` and `data` are continuous slices of the latched `decoded` register, so they update together.
  - Outputs hold their value until the next complete frame.
- Reset (async, any time, including mid-frame):
  - All outputs, the shift register, count and phase go to 0.
  - State goes to HUNT.

## Timing
- Valid pairs produce one decoded bit per 2 clocks.
- Latency: `decoded` updates on the rising edge that samples the second half of the 464th valid pair.
  - Counted from reset release, a gap-free frame latches at edge 928, which is encoded sample index 927.
- A simultaneous violation and count==464 cannot occur, because completion is checked only on valid pairs.
- The count is 9 bits and saturates. It must never wrap within a frame.
- A frame longer than 464 bits captures only its first 464 bits. A shorter frame followed by idle produces no output change.

## Structure
- Shared package `quic_rx_pkg` holds:
  - FRAME_BITS = 464, DATA_BITS = 134
  - Field offsets: SRC_MSB = 463, DST_MSB = 447
  - State enum HUNT / RECV / DONE
- One natural sub-module, `manchester_pair_dec`:
  - Handles phase tracking and pair classification.
  - Outputs: bit_valid, bit_val, idle, violation.
- The top level holds the FSM, counter, shift register and output latch.

## Test plan
- Reset: hold rst_n=0 with random `encoded` -> all outputs 0. Deassert mid-frame -> outputs stay 0 and the pairing restarts at the next sample.
- All-ones frame: 464 "01" pairs then "00" -> decoded = all 1s, source_port = 16'hFFFF, dest_port = 16'hFFFF, data = all 1s, latched exactly at edge 928.
- Field mapping:
  - Frame bits 0..15 = 16'h1234 MSB-first, bits 16..31 = 16'hABCD, remaining bits alternating 1,0 -> source_port = 16'h1234, dest_port = 16'hABCD.
  - data[133:0] = the alternating pattern, whose LSB is the last received bit.
- Long frame: 488 valid pairs (976 samples) then line held 0 -> only the first 464 bits are captured; the final 24 bits do not disturb outputs; idle returns to HUNT.
- Abort: a "11" violation after 100 valid bits, then a full 464-bit frame of 16'h0F0F repeated -> outputs reflect only the second frame.
- Back-to-back: two distinct frames separated by one "00" pair -> `decoded` shows frame 1, then frame 2, each at its own completion edge.
